// File: rtl/pwm_audio_decoder.sv
// Decodes a 1-bit PWM stream into one saturated PCM sample per FRAME_LEN-clock frame (valid/ready out).
// Optional macro PWM_DEC_DEGLITCH_EN inserts a 3-tap majority filter after the input synchronizer.
module pwm_audio_decoder #(
  parameter int WIDTH       = 8,
  parameter int FRAME_LEN   = 256,
  parameter int IDLE_FRAMES = 4
) (
  input  logic             CLK100MHZ,
  input  logic             BTNC,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] sample_data,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             locked,
  output logic             overrun,
  input  logic             overrun_clr
);

  localparam int FCW = $clog2(FRAME_LEN);
  localparam int HCW = $clog2(FRAME_LEN + 1);
  localparam int ICW = $clog2(IDLE_FRAMES + 1);
  localparam logic [FCW-1:0] FC_LAST  = FCW'(FRAME_LEN - 1);
  localparam logic [ICW-1:0] IDLE_MAX = ICW'(IDLE_FRAMES - 1);
  localparam longint SAT_VAL = (longint'(1) << WIDTH) - 1;

  typedef enum logic {HUNT, LOCKED} state_t;

  logic sync1, sync2, pwm_s, pwm_s_d, rise;

  always_ff @(posedge CLK100MHZ or negedge BTNC) begin
    if (!BTNC) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      pwm_s_d <= 1'b0;
    end else begin
      sync1   <= pwm_in;
      sync2   <= sync1;
      pwm_s_d <= pwm_s;
    end
  end

`ifdef PWM_DEC_DEGLITCH_EN
  logic tap1, tap2;

  always_ff @(posedge CLK100MHZ or negedge BTNC) begin
    if (!BTNC) begin
      tap1 <= 1'b0;
      tap2 <= 1'b0;
    end else begin
      tap1 <= sync2;
      tap2 <= tap1;
    end
  end

  // A lone high (or low) sample never forms a 2-of-3 majority, so it is dropped.
  assign pwm_s = (sync2 & tap1) | (sync2 & tap2) | (tap1 & tap2);
`else
  assign pwm_s = sync2;
`endif

  assign rise = pwm_s & ~pwm_s_d;

  state_t           state;
  logic [FCW-1:0]   fc;
  logic [HCW-1:0]   hc;
  logic [HCW-1:0]   hc_final;
  logic [ICW-1:0]   idle_cnt;
  logic             rise_seen;
  logic             frame_rise;
  logic [WIDTH-1:0] sample_next;

  // hc holds the earlier cycles of the frame; the current cycle is folded in here.
  always_comb begin
    hc_final   = hc + HCW'(pwm_s);
    frame_rise = rise_seen | rise;
    if (longint'(hc_final) > SAT_VAL) sample_next = {WIDTH{1'b1}};
    else                              sample_next = WIDTH'(hc_final);
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge CLK100MHZ or negedge BTNC) begin
    if (!BTNC) begin
      state        <= HUNT;
      fc           <= '0;
      hc           <= '0;
      idle_cnt     <= '0;
      rise_seen    <= 1'b0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (sample_valid && sample_ready) sample_valid <= 1'b0;
      if (overrun_clr) overrun <= 1'b0;

      case (state)
        HUNT: begin
          fc        <= '0;
          hc        <= '0;
          idle_cnt  <= '0;
          rise_seen <= 1'b0;
          // The rise cycle itself is frame cycle 0 and its high sample counts.
          if (enable && rise) begin
            state     <= LOCKED;
            fc        <= FCW'(1);
            hc        <= HCW'(pwm_s);
            rise_seen <= 1'b1;
          end
        end
        LOCKED: begin
          if (!enable) begin
            state     <= HUNT;
            fc        <= '0;
            hc        <= '0;
            idle_cnt  <= '0;
            rise_seen <= 1'b0;
          end else if (fc == FC_LAST) begin
            fc           <= '0;
            hc           <= '0;
            rise_seen    <= 1'b0;
            sample_data  <= sample_next;
            sample_valid <= 1'b1;
            if (sample_valid && !sample_ready) overrun <= 1'b1;
            if (frame_rise) begin
              idle_cnt <= '0;
            end else if (idle_cnt == IDLE_MAX) begin
              state    <= HUNT;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + ICW'(1);
            end
          end else begin
            fc        <= fc + FCW'(1);
            hc        <= hc + HCW'(pwm_s);
            rise_seen <= rise_seen | rise;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_audio_decoder.sv
// Directed bench for pwm_audio_decoder: windowed-sum reference model compared every cycle,
// plus literal expectations on key points and on the accepted-sample sequence.
`timescale 1ns/1ps
module tb_pwm_audio_decoder;

  localparam int N    = 256;
  localparam int IDLE = 4;
  localparam int SATV = 255;
`ifdef PWM_DEC_DEGLITCH_EN
  localparam int DLY = 3;
  localparam bit DG  = 1'b1;
`else
  localparam int DLY = 2;
  localparam bit DG  = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       pwm_in;
  logic [7:0] sample_data;
  logic       sample_valid;
  logic       sample_ready;
  logic       locked;
  logic       overrun;
  logic       overrun_clr;

  int checks = 0;
  int errors = 0;

  pwm_audio_decoder #(.WIDTH(8), .FRAME_LEN(N), .IDLE_FRAMES(IDLE)) dut (
    .CLK100MHZ   (clk),
    .BTNC        (rst_n),
    .enable      (enable),
    .pwm_in      (pwm_in),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .locked      (locked),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit hist [0:32767];
  int n = 8;
  bit mlocked = 0, mvld = 0, mov = 0;
  int mdata = 0, fstart = 0, lastrise = 0;

  function automatic bit psf(input int p);
    if (DG) return (hist[p-1] & hist[p-2]) | (hist[p-1] & hist[p-3]) | (hist[p-2] & hist[p-3]);
    return hist[p-1];
  endfunction

  always @(negedge rst_n) begin
    mlocked = 0; mvld = 0; mov = 0; mdata = 0;
  end

  always @(posedge clk) begin
    int c, sum, f, ldat;
    bit pn, rs, load, anyr;
    n++;
    if (!rst_n) begin
      hist[n] = 1'b0;
      mlocked = 0; mvld = 0; mov = 0; mdata = 0;
    end else begin
      hist[n] = pwm_in;
      c    = n - 1;
      pn   = psf(c);
      rs   = pn && !psf(c - 1);
      load = 0;
      ldat = 0;
      if (!mlocked) begin
        if (rs && enable) begin
          mlocked  = 1;
          fstart   = c;
          lastrise = 0;
        end
      end else if (!enable) begin
        mlocked = 0;
      end else if ((c - fstart) % N == N - 1) begin
        f = (c - fstart) / N;
        sum = 0;
        anyr = 0;
        for (int q = c - N + 1; q <= c; q++) begin
          sum += int'(psf(q));
          if (psf(q) && !psf(q - 1)) anyr = 1;
        end
        if (anyr) lastrise = f;
        load = 1;
        ldat = (sum > SATV) ? SATV : sum;
        if (f - lastrise >= IDLE) mlocked = 0;
      end
      if (overrun_clr) mov = 0;
      if (load) begin
        if (mvld && !sample_ready) mov = 1;
        mdata = ldat;
        mvld  = 1;
      end else if (mvld && sample_ready) begin
        mvld = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] md;
    md = mdata[7:0];
    checks++;
    if ({sample_valid, locked, overrun, sample_data} !== {mvld, mlocked, mov, md}) begin
      errors++;
      $display("FAIL model_cmp t=%0t: got v=%0b l=%0b o=%0b d=%0d, expected v=%0b l=%0b o=%0b d=%0d",
               $time, sample_valid, locked, overrun, sample_data, mvld, mlocked, mov, md);
    end
  end

  // ---------------- accepted-sample capture ----------------
  int got_q[$];
  int exp_q[$];

  always @(posedge clk)
    if (rst_n && sample_valid && sample_ready) got_q.push_back(int'(sample_data));

  task automatic check_capture(input string name);
    chk({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_s%0d", name, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // rmode: 0 ready high, 1 ready low, 2 ready high only on the cycle the decoder closes a frame
  task automatic frame(input int duty, input int glitch, input int rmode, input int len);
    for (int k = 0; k < len; k++) begin
      @(posedge clk); #1;
      pwm_in = (k < duty) || (k == glitch);
      case (rmode)
        0:       sample_ready = 1'b1;
        1:       sample_ready = 1'b0;
        default: sample_ready = (k == DLY - 1);
      endcase
    end
  endtask

  initial begin
    #20ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    rst_n = 1'b0; enable = 1'b1; pwm_in = 1'b0; sample_ready = 1'b1; overrun_clr = 1'b0;

    // Test 1: reset values, then asynchronous reset mid-frame with valid and overrun set
    repeat (5) @(posedge clk);
    #2;
    chk("rst_valid", sample_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_data", sample_data, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    frame(64, -1, 1, N);
    frame(64, -1, 1, N);
    frame(64, -1, 1, 100);
    chk("pre_rst_valid", sample_valid, 1);
    chk("pre_rst_overrun", overrun, 1);
    chk("pre_rst_data", sample_data, 64);
    chk("pre_rst_locked", locked, 1);
    @(posedge clk); #3;
    rst_n = 1'b0; pwm_in = 1'b0;
    #1;
    chk("async_rst_valid", sample_valid, 0);
    chk("async_rst_locked", locked, 0);
    chk("async_rst_overrun", overrun, 0);
    chk("async_rst_data", sample_data, 0);
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    sample_ready = 1'b1;
    got_q.delete();
    repeat (10) @(posedge clk);

    // Tests 2/3: duty 64 x3, then duty 0 until lock drops
    frame(64, -1, 0, N);
    chk("lock_after_first", locked, 1);
    frame(64, -1, 0, N);
    frame(64, -1, 0, N);
    repeat (4) frame(0, -1, 0, N);
    repeat (10) @(posedge clk);
    chk("unlock_after_idle0", locked, 0);
    exp_q = '{64, 64, 64, 0, 0, 0, 0};
    check_capture("duty64_then0");

    // Test 3b: constant high saturates
    repeat (5) frame(256, -1, 0, N);
    frame(0, -1, 0, N);
    chk("unlock_after_idle1", locked, 0);
    exp_q = '{255, 255, 255, 255, 255};
    check_capture("duty256");

    // Test 4: ready low over two frames -> overwrite and sticky overrun, then clear
    frame(100, -1, 1, N);
    frame(200, -1, 1, N);
    for (int k = 0; k < N; k++) begin
      @(posedge clk); #1;
      pwm_in       = 1'b0;
      sample_ready = (k >= 40);
      overrun_clr  = (k == 20);
      if (k == 10) begin
        chk("ovr_data", sample_data, 200);
        chk("ovr_valid", sample_valid, 1);
        chk("ovr_flag", overrun, 1);
      end
      if (k == 25) begin
        chk("ovr_cleared", overrun, 0);
        chk("ovr_data_held", sample_data, 200);
      end
    end
    overrun_clr = 1'b0;
    repeat (4) frame(0, -1, 0, N);
    repeat (10) @(posedge clk);
    chk("unlock_after_idle2", locked, 0);
    exp_q = '{200, 0, 0, 0, 0};
    check_capture("overrun");

    // Test 5: accept and new load on the same cycle
    frame(30, -1, 2, N);
    frame(40, -1, 2, N);
    frame(50, -1, 2, N);
    frame(0, -1, 2, N);
    chk("same_cycle_no_overrun", overrun, 0);
    repeat (4) frame(0, -1, 0, N);
    repeat (10) @(posedge clk);
    exp_q = '{30, 40, 50, 0, 0, 0, 0};
    check_capture("same_cycle");

    // Test 6: single-cycle glitch mid-frame on duty 10
    g = DG ? 10 : 11;
    frame(10, 100, 0, N);
    frame(10, 100, 0, N);
    repeat (5) frame(0, -1, 0, N);
    exp_q = '{g, g, 0, 0, 0, 0};
    check_capture("glitch");

    // enable low: no lock, no samples
    enable = 1'b0;
    frame(64, -1, 0, N);
    chk("disabled_locked", locked, 0);
    check_capture("disabled");
    enable = 1'b1;
    repeat (5) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
